// File: rtl/mvme_pkg.sv
// Shared types and constants for the 4x4 matrix-vector sequencer.
package mvme_pkg;

    localparam int Q_W          = 35;
    localparam int Q_FRAC       = 27;
    localparam int MVME_LATENCY = 10;
    localparam int MVME_N       = 4;

    typedef logic signed [Q_W-1:0] q8_27_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } mvme_state_e;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } mvme_tag_t;

endpackage

// File: rtl/mvme_tag_dly.sv
// Fixed-depth shift register with synchronous clear.
// Used to carry result tags alongside a fixed-latency engine.
module mvme_tag_dly #(
    parameter int DEPTH = 10,
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (i_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_q = r_sr[DEPTH-1];

endmodule

// File: rtl/mvme_row_sequencer.sv
// Issues one coefficient row per cycle to the multiply-sum engine and
// returns the four dot-product results as an indexed stream.
module mvme_row_sequencer
    import mvme_pkg::*;
#(
    parameter int W           = Q_W,
    parameter int MAC_LATENCY = MVME_LATENCY,
    parameter int N           = MVME_N
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         coef_we,
    input  logic [3:0]   coef_addr,
    input  logic [W-1:0] coef_wdata,
    input  logic [W-1:0] x0,
    input  logic [W-1:0] x1,
    input  logic [W-1:0] x2,
    input  logic [W-1:0] x3,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] a,
    output logic [W-1:0] b,
    output logic [W-1:0] c,
    output logic [W-1:0] d,
    output logic [W-1:0] e,
    output logic [W-1:0] f,
    output logic [W-1:0] g,
    output logic [W-1:0] h,
    input  logic [W-1:0] mac_total,
    input  logic         mac_overload,
    output logic         y_valid,
    output logic [1:0]   y_idx,
    output logic [W-1:0] y_data,
    output logic         y_overload,
    output logic         ovf_sticky
);

    mvme_state_e r_state;
    mvme_state_e w_state_nxt;
    logic [1:0]  r_row;
    logic [1:0]  w_row_nxt;
    logic [1:0]  w_row;
    logic        w_load;
    logic        w_accept;
    logic        w_we_ok;

    logic [W-1:0] r_bank [N*N];
    logic [W-1:0] r_x    [4];
    logic [W-1:0] w_x    [4];
    logic [W-1:0] w_m    [4];
    logic [W-1:0] r_opm  [4];
    logic [W-1:0] r_opx  [4];

    mvme_tag_t r_tag_in;
    mvme_tag_t w_tag_q;

    logic         r_y_valid;
    logic [1:0]   r_y_idx;
    logic [W-1:0] r_y_data;
    logic         r_y_ovl;
    logic         r_done;
    logic         r_sticky;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_load      = 1'b0;
        w_accept    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_load      = 1'b1;
                    w_row_nxt   = 2'd1;
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_load    = 1'b1;
                w_row_nxt = r_row + 2'd1;
                if (r_row == 2'd3) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_row   = (r_state == ST_ISSUE) ? r_row : 2'd0;
    assign w_we_ok = coef_we && (r_state == ST_IDLE);

    // A write landing with start must be visible to row 0 this cycle.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_m[i] = r_bank[{w_row, 2'(i)}];
            if (w_we_ok && coef_addr == {w_row, 2'(i)}) begin
                w_m[i] = coef_wdata;
            end
        end
        w_x[0] = w_accept ? x0 : r_x[0];
        w_x[1] = w_accept ? x1 : r_x[1];
        w_x[2] = w_accept ? x2 : r_x[2];
        w_x[3] = w_accept ? x3 : r_x[3];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N*N; i++) begin
                r_bank[i] <= '0;
            end
            for (int i = 0; i < 4; i++) begin
                r_x[i]   <= '0;
                r_opm[i] <= '0;
                r_opx[i] <= '0;
            end
            r_row     <= 2'd0;
            r_tag_in  <= '0;
            r_y_valid <= 1'b0;
            r_y_idx   <= 2'd0;
            r_y_data  <= '0;
            r_y_ovl   <= 1'b0;
            r_done    <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_row <= w_row_nxt;
            if (w_we_ok) begin
                r_bank[coef_addr] <= coef_wdata;
            end
            if (w_accept) begin
                r_x <= w_x;
            end
            for (int i = 0; i < 4; i++) begin
                r_opm[i] <= w_load ? w_m[i] : '0;
                r_opx[i] <= w_load ? w_x[i] : '0;
            end
            r_tag_in.valid <= w_load;
            r_tag_in.idx   <= w_row;

            r_y_valid <= w_tag_q.valid;
            r_y_idx   <= w_tag_q.valid ? w_tag_q.idx : 2'd0;
            r_y_data  <= w_tag_q.valid ? mac_total : '0;
            r_y_ovl   <= w_tag_q.valid & mac_overload;
            r_done    <= w_tag_q.valid && (w_tag_q.idx == 2'd3);

            if (w_accept) begin
                r_sticky <= 1'b0;
            end else if (w_tag_q.valid) begin
                r_sticky <= r_sticky | mac_overload;
            end
        end
    end

    mvme_tag_dly #(
        .DEPTH (MAC_LATENCY),
        .WIDTH ($bits(mvme_tag_t))
    ) u_tag_dly (
        .clk   (clk),
        .i_clr (rst),
        .i_d   (r_tag_in),
        .o_q   (w_tag_q)
    );

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign a          = r_opm[0];
    assign b          = r_opx[0];
    assign c          = r_opm[1];
    assign d          = r_opx[1];
    assign e          = r_opm[2];
    assign f          = r_opx[2];
    assign g          = r_opm[3];
    assign h          = r_opx[3];
    assign y_valid    = r_y_valid;
    assign y_idx      = r_y_idx;
    assign y_data     = r_y_data;
    assign y_overload = r_y_ovl;
    assign ovf_sticky = r_sticky;

endmodule

// File: tb/tb_mvme_row_sequencer.sv
// Bench for mvme_row_sequencer: engine model, frame-level scoreboard
// and directed frames with hand-computed results.
module tb_mvme_row_sequencer;

    localparam int W   = 35;
    localparam int LAT = 10;

    typedef logic signed [W-1:0] q_t;

    localparam q_t ONE  = 35'sd134217728;
    localparam q_t TWO  = 35'sd268435456;
    localparam q_t HALF = 35'sd67108864;
    localparam q_t M3   = -35'sd402653184;
    localparam q_t M15  = -35'sd201326592;
    localparam q_t H100 = 35'sd13421772800;
    localparam q_t QMAX = 35'sd17179869183;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic coef_we = 1'b0;
    logic [3:0] coef_addr = 4'd0;
    q_t coef_wdata = '0;
    q_t x0 = '0, x1 = '0, x2 = '0, x3 = '0;
    logic start = 1'b0;
    logic busy, done, y_valid, y_overload, ovf_sticky;
    q_t a, b, c, d, e, f, g, h, y_data;
    logic [1:0] y_idx;
    q_t mac_total;
    logic mac_overload;

    mvme_row_sequencer dut (
        .clk(clk), .rst(rst),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3),
        .start(start), .busy(busy), .done(done),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .mac_total(mac_total), .mac_overload(mac_overload),
        .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data),
        .y_overload(y_overload), .ovf_sticky(ovf_sticky)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic cmp(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
        end
    endtask

    // Q8.27 dot product with saturation; overload when saturated.
    function automatic void eng(input q_t m[4], input q_t v[4],
                                output q_t tot, output logic ov);
        logic signed [73:0] acc;
        logic signed [69:0] p;
        acc = '0;
        for (int i = 0; i < 4; i++) begin
            p = m[i] * v[i];
            acc += (p >>> 27);
        end
        ov = 1'b1;
        if (acc > 74'sd17179869183) tot = QMAX;
        else if (acc < -74'sd17179869184) tot = -QMAX - 35'sd1;
        else begin
            tot = acc[W-1:0];
            ov  = 1'b0;
        end
    endfunction

    q_t   eng_tot [LAT+1];
    logic eng_ovl [LAT+1];
    assign mac_total    = eng_tot[LAT];
    assign mac_overload = eng_ovl[LAT];

    initial begin
        for (int i = 0; i <= LAT; i++) begin
            eng_tot[i] = '0;
            eng_ovl[i] = 1'b0;
        end
    end

    always @(negedge clk) begin : engine
        q_t em[4];
        q_t ev[4];
        q_t t;
        logic o;
        em = '{a, c, e, g};
        ev = '{b, d, f, h};
        eng(em, ev, t, o);
        if (cyc < 1) begin
            t = '0;
            o = 1'b0;
        end
        eng_tot[0] <= t;
        eng_ovl[0] <= o;
        for (int i = 1; i <= LAT; i++) begin
            eng_tot[i] <= eng_tot[i-1];
            eng_ovl[i] <= eng_ovl[i-1];
        end
    end

    // Frame-level model: last accepted frame, its start cycle and results.
    q_t   mb [16];
    bit   fvalid = 1'b0;
    int   fT = 0;
    q_t   fm [16];
    q_t   fx [4];
    q_t   fy [4];
    logic fo [4];

    initial for (int i = 0; i < 16; i++) mb[i] = '0;

    always @(negedge clk) begin : chk
        int   k;
        logic eb, ev, ed, es;
        logic [1:0] ei;
        q_t   ey;
        logic eo;
        q_t   eop [8];
        q_t   rm [4];
        eb = 0; ev = 0; ed = 0; es = 0; ei = 0; ey = '0; eo = 0;
        for (int i = 0; i < 8; i++) eop[i] = '0;
        if (fvalid) begin
            k  = cyc - fT;
            eb = (k >= 1 && k <= 15);
            if (k >= 1 && k <= 4) begin
                for (int i = 0; i < 4; i++) begin
                    eop[2*i]   = fm[(k-1)*4 + i];
                    eop[2*i+1] = fx[i];
                end
            end
            if (k >= 12 && k <= 15) begin
                ev = 1'b1;
                ei = 2'(k - 12);
                ey = fy[k-12];
                eo = fo[k-12];
            end
            ed = (k == 15);
            for (int r = 0; r < 4; r++)
                if (k >= 12 + r) es |= fo[r];
        end
        if (cyc >= 1) begin
            cmp("busy", busy, eb);
            cmp("done", done, ed);
            cmp("a", a, eop[0]);
            cmp("b", b, eop[1]);
            cmp("c", c, eop[2]);
            cmp("d", d, eop[3]);
            cmp("e", e, eop[4]);
            cmp("f", f, eop[5]);
            cmp("g", g, eop[6]);
            cmp("h", h, eop[7]);
            cmp("y_valid", y_valid, ev);
            cmp("y_idx", y_idx, ei);
            cmp("y_data", y_data, ey);
            cmp("y_overload", y_overload, eo);
            cmp("ovf_sticky", ovf_sticky, es);
        end
        if (rst) begin
            fvalid = 1'b0;
            for (int i = 0; i < 16; i++) mb[i] = '0;
        end else begin
            if (coef_we && !eb) mb[coef_addr] = coef_wdata;
            if (start && !eb) begin
                fvalid = 1'b1;
                fT = cyc;
                fm = mb;
                fx = '{x0, x1, x2, x3};
                for (int r = 0; r < 4; r++) begin
                    for (int i = 0; i < 4; i++) rm[i] = fm[r*4 + i];
                    eng(rm, fx, fy[r], fo[r]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int k);
        while (cyc < k) tick();
    endtask

    task automatic neg_at(input int k);
        wait_cyc(k);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] ad, input q_t v);
        coef_we = 1'b1;
        coef_addr = ad;
        coef_wdata = v;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic fill(input q_t dg, input q_t off);
        for (int i = 0; i < 16; i++)
            wr(4'(i), (i / 4 == i % 4) ? dg : off);
    endtask

    task automatic setx(input q_t v0, input q_t v1, input q_t v2, input q_t v3);
        x0 = v0; x1 = v1; x2 = v2; x3 = v3;
    endtask

    task automatic go(output int t);
        t = cyc;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin : timeout
        #200000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

    initial begin : stim
        int t;
        int t2;
        q_t want [4];
        wait_cyc(3);
        rst = 1'b0;
        neg_at(3);
        cmp("rst_busy", busy, 0);
        cmp("rst_yv", y_valid, 0);
        cmp("rst_a", a, 0);

        // identity matrix
        tick();
        fill(ONE, '0);
        setx(ONE, TWO, M3, HALF);
        go(t);
        neg_at(t + 1);
        cmp("id_busy_T1", busy, 1);
        want = '{ONE, TWO, M3, HALF};
        for (int r = 0; r < 4; r++) begin
            neg_at(t + 12 + r);
            cmp("id_y", y_data, want[r]);
            cmp("id_idx", y_idx, r);
        end
        cmp("id_done", done, 1);
        neg_at(t + 16);
        cmp("id_busy_T16", busy, 0);

        // all-ones matrix, large vector: every row saturates
        tick();
        fill(ONE, ONE);
        setx(H100, H100, H100, H100);
        go(t);
        neg_at(t + 12);
        cmp("ov_yo", y_overload, 1);
        cmp("ov_y", y_data, QMAX);
        neg_at(t + 16);
        cmp("ov_sticky", ovf_sticky, 1);

        // restarts during busy ignored; restart at T+16 accepted
        tick();
        setx(ONE, ONE, ONE, ONE);
        go(t);
        neg_at(t + 1);
        cmp("st_clear", ovf_sticky, 0);
        wait_cyc(t + 5);
        go(t2);
        wait_cyc(t + 15);
        go(t2);
        wait_cyc(t + 16);
        go(t2);
        neg_at(t + 17);
        cmp("re_busy", busy, 1);
        neg_at(t + 27);
        cmp("re_yv27", y_valid, 0);
        neg_at(t + 28);
        cmp("re_yv28", y_valid, 1);
        cmp("re_y", y_data, 35'sd536870912);
        wait_cyc(t2 + 17);

        // write while busy dropped; write with start used
        fill(ONE, '0);
        setx(ONE, TWO, M3, HALF);
        go(t);
        wait_cyc(t + 3);
        wr(4'd5, TWO);
        wait_cyc(t + 16);
        go(t);
        neg_at(t + 13);
        cmp("wb_old", y_data, TWO);
        wait_cyc(t + 16);
        coef_we = 1'b1;
        coef_addr = 4'd5;
        coef_wdata = TWO;
        go(t);
        coef_we = 1'b0;
        neg_at(t + 13);
        cmp("wb_new", y_data, 35'sd536870912);
        wait_cyc(t + 16);

        // reset mid-frame
        go(t);
        wait_cyc(t + 8);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        neg_at(t + 9);
        cmp("ab_busy", busy, 0);
        cmp("ab_a", a, 0);
        for (int i = 0; i < 15; i++) begin
            cmp("ab_yv", y_valid, 0);
            cmp("ab_done", done, 0);
            tick();
            @(negedge clk);
        end

        // sparse matrix after reset
        tick();
        fill('0, '0);
        wr(4'd11, M15);
        setx(ONE, ONE, ONE, TWO);
        go(t);
        neg_at(t + 3);
        cmp("sp_a", a, 0);
        cmp("sp_b", b, ONE);
        cmp("sp_f", f, ONE);
        cmp("sp_g", g, M15);
        cmp("sp_h", h, TWO);
        neg_at(t + 5);
        cmp("sp_a5", a, 0);
        cmp("sp_g5", g, 0);
        cmp("sp_h5", h, 0);
        neg_at(t + 12);
        cmp("sp_y0", y_data, 0);
        neg_at(t + 14);
        cmp("sp_y2", y_data, M3);
        cmp("sp_i2", y_idx, 2);
        wait_cyc(t + 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mvme_row_sequencer.md
Name: mvme_row_sequencer

Overview:
Upstream and return-side controller for the 4-channel Q8.27 multiply-sum engine. It holds a 4x4 coefficient matrix and a latched 4-element input vector. On start it issues one matrix row per cycle as four operand pairs. It tracks each row through the engine's fixed latency and emits the four dot-product results as an indexed stream with overload status, computing y = M * x per frame.

Parameters:
W, 35, operand/result width (Q8.27, signed)
MAC_LATENCY, 10, cycles from operands presented on a..h to matching mac_total/mac_overload
N, 4, matrix dimension (fixed; rows = columns = 4)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
coef_we  in  1  coefficient write strobe
coef_addr  in  4  row*4+col
coef_wdata  in  W  coefficient value
x0,x1,x2,x3  in  W each  input vector, sampled on accepted start
start  in  1  frame request pulse
busy  out  1  frame in progress
done  out  1  one-cycle pulse with last result
a,b,c,d,e,f,g,h  out  W each  registered operand pairs to engine
mac_total  in  W  engine total-sum output
mac_overload  in  1  engine overload flag, aligned with mac_total
y_valid  out  1  result strobe
y_idx  out  2  row index of y_data
y_data  out  W  result row
y_overload  out  1  overload for this row
ovf_sticky  out  1  OR of y_overload over current/last frame

Behaviour:
- Reset: all outputs 0. Coefficient bank, latched vector, tag pipeline and FSM cleared. FSM enters IDLE.
- FSM IDLE -> ISSUE -> DRAIN -> IDLE.
- IDLE: start sampled at cycle T is accepted. x0..x3 are latched, ovf_sticky is cleared, and busy=1 from T+1.
- ISSUE: row r (0..3) operands appear on outputs in cycle T+1+r:
  a=M[r][0], b=x0, c=M[r][1], d=x1, e=M[r][2], f=x2, g=M[r][3], h=x3.
  After r=3 the FSM enters DRAIN.
- Outside ISSUE, a..h = 0.
- Tag pipeline: MAC_LATENCY stages of {valid, idx[1:0]}. Each entry is loaded in the same cycle its operands are presented. The pipeline output is aligned with mac_total.
- When the pipeline output is valid, y_valid/y_idx/y_data/y_overload are registered 1 cycle later. Row r result appears at T+2+r+MAC_LATENCY, i.e. T+12..T+15 at default latency.
- ovf_sticky |= y_overload on each y_valid.
- done=1 in the same cycle as the y_valid with y_idx=3. busy deasserts the following cycle (T+16), when the FSM returns to IDLE.
- start while busy=1 is ignored: no queuing, no effect on the frame in progress. Earliest accepted restart is the cycle busy reads 0.
- Coefficient writes:
  - accepted only when busy=0;
  - writes during busy are dropped, so the bank is frozen for the frame;
  - write and start in the same IDLE cycle: the write commits first and the frame uses the new value.
- mac_total/mac_overload are ignored when the tag output is invalid. Stale engine output after reset is never reported.
- Reset mid-frame: immediate return to IDLE. No y_valid or done is produced for the aborted frame, including results still in flight.
- No arithmetic in this block. Data passes through unmodified at full width W.

Decomposition:
- Shared package mvme_pkg:
  - Q_W=35, Q_FRAC=27, MVME_LATENCY=10, MVME_N=4;
  - typedef q8_27_t (signed [34:0]);
  - FSM state enum.
- One sub-module, mvme_tag_dly: a parameterised depth x width shift register with synchronous clear. It carries the {valid, idx} tags and is reusable for other latency-tracked stages.

Test Plan:
- Bench setup: behavioural engine model with 10-cycle latency and saturation-driven overload. 1.0 = 134217728 in Q8.27.
- Identity M, x=[1.0, 2.0, -3.0, 0.5], start at T -> y_idx 0..3 at T+12..T+15 with y_data = 134217728, 268435456, -402653184, 67108864; done at T+15; busy low at T+16.
- M all 1.0, x=[100.0, 100.0, 100.0, 100.0] -> every row overflows and the engine flags overload -> y_overload=1 on all four rows; ovf_sticky=1 after the frame; next frame start clears it to 0.
- start pulsed at T+5 and at T+15 during a frame -> both ignored, one frame only. start at T+16 -> second frame accepted; its first y_valid at T+28.
- coef_we to addr 5 with 2.0 while busy -> bank unchanged; next frame's row 1 result uses the old value. Same write while idle, together with start -> new value used.
- rst asserted at T+8 mid-frame -> all outputs 0 next cycle. No y_valid or done for the following 15 cycles even though the model still drives in-flight results. A new start after reset runs normally.
- Sparse M (M[2][3]=-1.5, others 0), x3=2.0 -> y2=-402653184, other rows 0. Check a..h show row 2 operands exactly at T+3 and are 0 at T+5.
